// File: rtl/dpram_1024_60bit_fifo_ctrl_if.sv
// Bundle of the signals between the FIFO controller, its producer/consumer
// and the external 1024x60 dual-port RAM macro.
//   slave  : the controller's view (takes in_*, out_ready, ram_out_b;
//            drives in_ready, out_*, count and the RAM port A/B controls)
//   master : the surrounding environment's view (the opposite directions)
// Signals:
//   in_valid/in_ready/in_data     producer handshake, push = in_valid & in_ready
//   out_valid/out_ready/out_data  consumer handshake, pop = out_valid & out_ready
//   count                         words held in total, 0..NUM_WORDS
//   ram_address_a/wren_a/data_a   RAM port A (write side)
//   ram_address_b/wren_b/data_b   RAM port B (read side, never written)
//   ram_out_b                     RAM port B registered read data
interface dpram_1024_60bit_fifo_ctrl_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 60
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [AWIDTH:0]   count;
  logic [AWIDTH-1:0] ram_address_a;
  logic              ram_wren_a;
  logic [DWIDTH-1:0] ram_data_a;
  logic [AWIDTH-1:0] ram_address_b;
  logic              ram_wren_b;
  logic [DWIDTH-1:0] ram_data_b;
  logic [DWIDTH-1:0] ram_out_b;

  modport slave (
    input  in_valid, in_data, out_ready, ram_out_b,
    output in_ready, out_valid, out_data, count,
           ram_address_a, ram_wren_a, ram_data_a,
           ram_address_b, ram_wren_b, ram_data_b
  );

  modport master (
    output in_valid, in_data, out_ready, ram_out_b,
    input  in_ready, out_valid, out_data, count,
           ram_address_a, ram_wren_a, ram_data_a,
           ram_address_b, ram_wren_b, ram_data_b
  );
endinterface

// File: rtl/dpram_1024_60bit_fifo_ctrl.sv
// Streaming FIFO controller for an external 1024x60 dual-port RAM.
// Port A of the RAM takes every accepted producer word at the write pointer.
// Port B reads ahead (1-clock latency) into a 2-entry in-order output buffer
// whose head drives the consumer side, so out_data is always a register.
// Ports:
//   clk    single clock, everything on posedge
//   reset  asynchronous, active-high; clears pointers, counters and buffer
//          (RAM contents are left alone, any in-flight read is dropped)
//   bus    controller side (slave modport) of dpram_1024_60bit_fifo_ctrl_if
// NUM_WORDS must equal 2**AWIDTH so the pointers wrap naturally.
module dpram_1024_60bit_fifo_ctrl #(
  parameter int AWIDTH    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DWIDTH    = 60
) (
  input  logic clk,
  input  logic reset,
  dpram_1024_60bit_fifo_ctrl_if.slave bus
);

  localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH+1)'(NUM_WORDS);

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   ram_cnt;
  logic              inflight;
  logic [1:0]        buf_occ;
  logic [DWIDTH-1:0] buf_head;
  logic [DWIDTH-1:0] buf_tail;
  logic [AWIDTH:0]   count_q;

  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              rd_en;
  logic [2:0]        occ_after;

  // Handshake decode. in_ready looks only at the registered count so the
  // producer side never depends combinationally on the consumer.
  always_comb begin
    in_ready  = !reset && (count_q < FULL_COUNT);
    out_valid = (buf_occ != 2'd0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
    // Buffer slots that will be taken once the word already in flight lands
    // and this cycle's pop has left; a new read may only be issued if that
    // still leaves room for its own word.
    occ_after = {1'b0, buf_occ} + {2'b00, inflight} - {2'b00, pop};
    rd_en     = (ram_cnt != '0) && (occ_after < 3'd2);
  end

  // RAM and consumer-facing outputs. Port B is read-only; its address always
  // shows the read pointer and the data is kept only when a read was issued.
  always_comb begin
    bus.in_ready      = in_ready;
    bus.out_valid     = out_valid;
    bus.out_data      = buf_head;
    bus.count         = count_q;
    bus.ram_address_a = wr_ptr;
    bus.ram_wren_a    = push;
    bus.ram_data_a    = bus.in_data;
    bus.ram_address_b = rd_ptr;
    bus.ram_wren_b    = 1'b0;
    bus.ram_data_b    = '0;
  end

  // Pointer and occupancy bookkeeping. ram_cnt only counts words that have
  // been written but not yet read, so a word written this edge cannot be read
  // until the next cycle and the two ports never race on one address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      inflight <= rd_en;
      case ({push, rd_en})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Two-entry output buffer, head first. A read that was in flight lands at
  // the first free slot after any pop, so order is kept when a pop and an
  // append hit the same edge. The read-issue rule keeps occupancy at two or
  // below, so an append never finds the buffer full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_occ  <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      if (inflight && pop) begin
        if (buf_occ == 2'd2) begin
          buf_head <= buf_tail;
          buf_tail <= bus.ram_out_b;
        end else begin
          buf_head <= bus.ram_out_b;
        end
      end else if (inflight) begin
        if (buf_occ == 2'd0) begin
          buf_head <= bus.ram_out_b;
        end else begin
          buf_tail <= bus.ram_out_b;
        end
        buf_occ <= buf_occ + 2'd1;
      end else if (pop) begin
        buf_head <= buf_tail;
        buf_occ  <= buf_occ - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpram_1024_60bit_fifo_ctrl.sv
// Self-checking bench for dpram_1024_60bit_fifo_ctrl, with a behavioural
// 1024x60 dual-port RAM (1-clock registered port B) standing in for the macro.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dpram_1024_60bit_fifo_ctrl;

  localparam int AWIDTH    = 10;
  localparam int NUM_WORDS = 1024;
  localparam int DWIDTH    = 60;

  logic clk;
  logic reset;

  dpram_1024_60bit_fifo_ctrl_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus();

  dpram_1024_60bit_fifo_ctrl #(
    .AWIDTH(AWIDTH), .NUM_WORDS(NUM_WORDS), .DWIDTH(DWIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM macro stand-in
  logic [DWIDTH-1:0] mem [NUM_WORDS];
  logic [DWIDTH-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_wren_a) mem[bus.ram_address_a] <= bus.ram_data_a;
    ram_q <= mem[bus.ram_address_b];
  end
  assign bus.ram_out_b = ram_q;

  int testCount;
  int failCount;

  // Reference model: queue of words held, and a plain push/pop counter
  logic [DWIDTH-1:0] modelQ[$];
  int                modelCount;
  bit                stallPrev;
  logic [DWIDTH-1:0] heldData;
  int                cycleNo;
  int                firstPop;
  int                lastPop;
  int                popTotal;
  int                pushTotal;
  logic [DWIDTH-1:0] lastPopped;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycleNo);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelCount = 0;
    stallPrev  = 1'b0;
  endtask

  // One clock of stimulus. Called on a falling edge: checks the outputs
  // against the model, drives the inputs, advances the model by the
  // handshakes that will happen at the next rising edge, then returns on
  // the following falling edge.
  task automatic applyStimulus(input bit iv, input logic [DWIDTH-1:0] d,
                               input bit ordy);
    bit pushNow;
    bit popNow;
    checkOutput("count", 64'(bus.count), 64'(modelCount));
    checkOutput("in_ready", 64'(bus.in_ready), 64'(modelCount < NUM_WORDS));
    if (bus.out_valid) begin
      if (modelQ.size() == 0) checkOutput("valid_when_empty", 64'(1), 64'(0));
      else checkOutput("out_data", 64'(bus.out_data), 64'(modelQ[0]));
    end
    if (stallPrev) begin
      checkOutput("stall_valid", 64'(bus.out_valid), 64'(1));
      checkOutput("stall_data", 64'(bus.out_data), 64'(heldData));
    end
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    pushNow = iv && bus.in_ready;
    popNow  = bus.out_valid && ordy;
    #1;
    checkOutput("wren_a", 64'(bus.ram_wren_a), 64'(pushNow));
    if (pushNow) begin
      modelQ.push_back(d);
      pushTotal++;
    end
    if (popNow) begin
      lastPopped = modelQ[0];
      if (modelQ.size() != 0) void'(modelQ.pop_front());
      if (firstPop < 0) firstPop = cycleNo;
      lastPop = cycleNo;
      popTotal++;
    end
    modelCount = modelCount + int'(pushNow) - int'(popNow);
    stallPrev  = bus.out_valid && !ordy;
    heldData   = bus.out_data;
    @(posedge clk);
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic clearStats();
    firstPop  = -1;
    lastPop   = -1;
    popTotal  = 0;
    pushTotal = 0;
  endtask

  initial begin
    int guard;
    logic [DWIDTH-1:0] rdata;
    testCount = 0;
    failCount = 0;
    cycleNo   = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    modelReset();
    clearStats();

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(bus.out_data), 64'(0));
    checkOutput("rst_count", 64'(bus.count), 64'(0));
    checkOutput("rst_wren_a", 64'(bus.ram_wren_a), 64'(0));
    checkOutput("wren_b", 64'(bus.ram_wren_b), 64'(0));
    checkOutput("data_b", 64'(bus.ram_data_b), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_in_ready", 64'(bus.in_ready), 64'(1));

    // Test 1: fill to capacity with the consumer stalled; 1025th word refused
    for (int i = 0; i < NUM_WORDS + 1; i++) applyStimulus(1'b1, DWIDTH'(i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_count", 64'(bus.count), 64'(NUM_WORDS));
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("full_head", 64'(bus.out_data), 64'(0));
    checkOutput("full_pushes", 64'(pushTotal), 64'(NUM_WORDS));

    // Test 2: drain, one word per clock, in order
    clearStats();
    guard = 0;
    while (modelQ.size() != 0 && guard < 1200) begin
      checkOutput("drain_valid", 64'(bus.out_valid), 64'(1));
      applyStimulus(1'b0, '0, 1'b1);
      guard++;
    end
    checkOutput("drain_pops", 64'(popTotal), 64'(NUM_WORDS));
    checkOutput("drain_span", 64'(lastPop - firstPop), 64'(NUM_WORDS - 1));
    checkOutput("drain_last", 64'(lastPopped), 64'(NUM_WORDS - 1));
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_valid_end", 64'(bus.out_valid), 64'(0));
    checkOutput("drain_count_end", 64'(bus.count), 64'(0));

    // Test 3: single word latency through an empty FIFO
    applyStimulus(1'b1, DWIDTH'('hABC), 1'b1);
    checkOutput("lat_after_e0", 64'(bus.out_valid), 64'(0));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_after_e1", 64'(bus.out_valid), 64'(0));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_after_e2_valid", 64'(bus.out_valid), 64'(1));
    checkOutput("lat_after_e2_data", 64'(bus.out_data), 64'('hABC));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("lat_count_end", 64'(bus.count), 64'(0));
    checkOutput("lat_valid_end", 64'(bus.out_valid), 64'(0));

    // Test 4: continuous streaming of 3000 words, pointers wrap twice
    clearStats();
    guard = 0;
    while (popTotal < 3000 && guard < 3200) begin
      applyStimulus(pushTotal < 3000, DWIDTH'(pushTotal + 'h100), 1'b1);
      guard++;
    end
    checkOutput("stream_pops", 64'(popTotal), 64'(3000));
    checkOutput("stream_no_gaps", 64'(lastPop - firstPop), 64'(2999));
    checkOutput("stream_last", 64'(lastPopped), 64'(2999 + 'h100));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stream_count_end", 64'(bus.count), 64'(0));

    // Test 5: random handshakes, 5000 words, then drain
    clearStats();
    guard = 0;
    while (pushTotal < 5000 && guard < 30000) begin
      rdata = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), rdata, 1'($urandom_range(0, 1)));
      guard++;
    end
    checkOutput("rand_pushed", 64'(pushTotal), 64'(5000));
    guard = 0;
    while (modelQ.size() != 0 && guard < 6000) begin
      applyStimulus(1'b0, '0, 1'b1);
      guard++;
    end
    checkOutput("rand_popped", 64'(popTotal), 64'(5000));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rand_count_end", 64'(bus.count), 64'(0));

    // Test 6: asynchronous reset in the middle of traffic
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DWIDTH'(i + 'h70), 1'b0);
    applyStimulus(1'b1, DWIDTH'('h77), 1'b1);
    checkOutput("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("mid_rst_data", 64'(bus.out_data), 64'(0));
    checkOutput("mid_rst_count", 64'(bus.count), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("mid_rst_wren_a", 64'(bus.ram_wren_a), 64'(0));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_count", 64'(bus.count), 64'(0));
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_valid", 64'(bus.out_valid), 64'(0));
    clearStats();
    applyStimulus(1'b1, DWIDTH'('h5), 1'b1);
    guard = 0;
    while (popTotal == 0 && guard < 10) begin
      applyStimulus(1'b0, '0, 1'b1);
      guard++;
    end
    checkOutput("post_rst_popped", 64'(popTotal), 64'(1));
    checkOutput("post_rst_first", 64'(lastPopped), 64'('h5));
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_pops_total", 64'(popTotal), 64'(1));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
